// File: rtl/dual_port_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// Read data updates only on cycles where read_en is high and holds otherwise.
module dual_port_ram #(
  parameter int    ITEM_COUNT = 800,
  parameter int    DATA_WIDTH = 8,
  parameter string RAM_STYLE  = "auto",
  localparam int   ADDR_W     = $clog2(ITEM_COUNT)
) (
  input  logic                  clock_i,
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [ADDR_W-1:0]     read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [ITEM_COUNT];

  // Write port: store the producer word at the write address
  always_ff @(posedge clock_i) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  // Read port: one-cycle latency, output held while read_en is low
  always_ff @(posedge clock_i) begin
    if (read_en) begin
      read_data <= mem[read_addr];
    end
  end

endmodule

// File: rtl/stream_ram_fifo.sv
// Valid/ready FIFO around a dual-port RAM with a first-word-fall-through
// output. The RAM read register doubles as the output stage, so total
// capacity is DEPTH+1 words. Pointers wrap at DEPTH, which need not be a
// power of two.
module stream_ram_fifo #(
  parameter int    DEPTH      = 800,
  parameter int    DATA_WIDTH = 8,
  parameter string RAM_STYLE  = "auto"
) (
  input  logic                        clock_i,
  input  logic                        reset_ni,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [DATA_WIDTH-1:0]       in_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_WIDTH-1:0]       out_data_o,
  output logic [$clog2(DEPTH+2)-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int RC_W  = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(DEPTH+2);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [RC_W-1:0]  ram_count;
  logic             ram_full;
  logic             push;
  logic             pop;
  logic             fetch;

  // Pointer advance with explicit wrap so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH-1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  // Handshake decode; ready is independent of the consumer so a full FIFO
  // never accepts a word even when the head is being popped
  always_comb begin
    ram_full   = (ram_count == RC_W'(DEPTH));
    in_ready_o = reset_ni & ~flush_i & ~ram_full;
    push       = in_valid_i & in_ready_o;
    pop        = out_valid_o & out_ready_i;
    fetch      = (ram_count != '0) & (~out_valid_o | out_ready_i);
    count_o    = CNT_W'(ram_count) + CNT_W'(out_valid_o);
  end

  // Controller state; reset and flush clear everything, flush wins over traffic
  always_ff @(posedge clock_i) begin
    if (!reset_ni || flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_count   <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (fetch) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, fetch})
        2'b10:   ram_count <= ram_count + 1'b1;
        2'b01:   ram_count <= ram_count - 1'b1;
        default: ram_count <= ram_count;
      endcase
      if (fetch) begin
        out_valid_o <= 1'b1;
      end else if (pop) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  // Storage; read data feeds out_data_o directly and holds during a stall
  dual_port_ram #(
    .ITEM_COUNT (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_STYLE  (RAM_STYLE)
  ) u_ram (
    .clock_i    (clock_i),
    .write_en   (push),
    .write_addr (wr_ptr),
    .write_data (in_data_i),
    .read_en    (fetch),
    .read_addr  (rd_ptr),
    .read_data  (out_data_o)
  );

endmodule

// File: tb/tb_stream_ram_fifo.sv
// Bench for stream_ram_fifo with DEPTH=4: queue-based reference model plus
// per-scenario directed and randomized checks.
module tb_stream_ram_fifo;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int CW    = $clog2(DEPTH+2);
  localparam int VW    = 2 + CW + DW;

  logic          clock_i = 1'b0;
  logic          reset_ni;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] count_o;

  always #5 clock_i = ~clock_i;

  stream_ram_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .RAM_STYLE("auto")) dut (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (count_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: words waiting in RAM, plus the visible head word
  logic [DW-1:0] mq[$];
  bit            m_ov;
  logic [DW-1:0] m_od;

  // Scoreboards of accepted and delivered words
  logic [DW-1:0] acc_q[$];
  logic [DW-1:0] got_q[$];

  logic [VW-1:0] obs_vec, exp_vec;
  logic          obs_ready, obs_valid;
  logic [DW-1:0] obs_data;
  logic [CW-1:0] obs_count;

  task automatic drive_cycle(input bit iv, input logic [DW-1:0] d, input bit ordy,
                             input bit fl, input bit rn);
    bit e_ready, fetch, pop;
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    reset_ni    = rn;
    @(negedge clock_i);
    obs_ready = in_ready_o;
    obs_valid = out_valid_o;
    obs_data  = out_data_o;
    obs_count = count_o;
    e_ready = rn && !fl && (mq.size() != DEPTH);
    exp_vec = {e_ready, m_ov, CW'(mq.size() + int'(m_ov)), (m_ov ? m_od : {DW{1'b0}})};
    obs_vec = {in_ready_o, out_valid_o, count_o, ((out_valid_o === 1'b1) ? out_data_o : {DW{1'b0}})};
    if ((out_valid_o === 1'b1) && ordy && rn && !fl) got_q.push_back(out_data_o);
    if (iv && (in_ready_o === 1'b1)) acc_q.push_back(d);
    if (!rn || fl) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      fetch = (mq.size() != 0) && (!m_ov || ordy);
      pop   = m_ov && ordy;
      if (fetch) begin
        m_od = mq.pop_front();
        m_ov = 1'b1;
      end else if (pop) begin
        m_ov = 1'b0;
      end
      if (iv && e_ready) mq.push_back(d);
    end
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_boards();
    acc_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=%h", obs_vec, exp_vec);
    end
    checks++;
    if (obs_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_low got=%b exp=0", obs_ready);
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs_vec, exp_vec);
    end
    checks++;
    if (obs_ready !== 1'b1 || obs_count !== '0 || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_state got=rdy%b v%b c%0d exp=rdy1 v0 c0",
               obs_ready, obs_valid, obs_count);
    end
  endtask

  task automatic test_single();
    int first_v = -1;
    logic [CW-1:0] cnt[6];
    clear_boards();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(c == 0, 8'h11, 1'b1, 1'b0, 1'b1);
      cnt[c] = obs_count;
      if (obs_valid === 1'b1 && first_v < 0) first_v = c;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL single_cycle c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    checks++;
    if (first_v != 2) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=2", first_v);
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h11) begin
      failures++;
      $display("FAIL single_data got_n=%0d exp_n=1 exp=11", got_q.size());
    end
    checks++;
    if (cnt[1] !== 3'd1 || cnt[2] !== 3'd1 || cnt[3] !== 3'd0) begin
      failures++;
      $display("FAIL single_count got=%0d,%0d,%0d exp=1,1,0", cnt[1], cnt[2], cnt[3]);
    end
  endtask

  task automatic test_full();
    logic ready_after;
    clear_boards();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b1, DW'(c + 1), 1'b0, 1'b0, 1'b1);
      if (c == 5) ready_after = obs_ready;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL full_fill c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (acc_q.size() != 5 || ready_after !== 1'b0 || obs_count !== 3'd5) begin
      failures++;
      $display("FAIL full_state got=acc%0d rdy%b c%0d exp=acc5 rdy0 c5",
               acc_q.size(), ready_after, obs_count);
    end
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL full_drain c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    checks++;
    begin
      bit ok = (got_q.size() == 5);
      for (int i = 0; i < got_q.size() && ok; i++) ok = (got_q[i] === DW'(i + 1));
      if (!ok) begin
        failures++;
        $display("FAIL full_order got_n=%0d exp_n=5 (01..05)", got_q.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_p = -1, last_p = -1;
    bit cnt_ok = 1'b1;
    clear_boards();
    for (int c = 0; c < 24; c++) begin
      drive_cycle(c < 20, DW'(c), 1'b1, 1'b0, 1'b1);
      if (obs_valid === 1'b1) begin
        if (first_p < 0) first_p = c;
        last_p = c;
      end
      if (c >= 2 && c < 20 && obs_count !== 3'd2) cnt_ok = 1'b0;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL b2b_cycle c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    checks++;
    if (first_p != 2 || last_p != 21 || !cnt_ok) begin
      failures++;
      $display("FAIL b2b_timing got=first%0d last%0d cnt_ok%0d exp=first2 last21 cnt_ok1",
               first_p, last_p, cnt_ok);
    end
    checks++;
    begin
      bit ok = (got_q.size() == 20);
      for (int i = 0; i < got_q.size() && ok; i++) ok = (got_q[i] === DW'(i));
      if (!ok) begin
        failures++;
        $display("FAIL b2b_order got_n=%0d exp_n=20 (0..19)", got_q.size());
      end
    end
  endtask

  task automatic test_stall();
    logic          pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;
    int            c  = 0;
    clear_boards();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b1);
    while ((acc_q.size() < 100 || got_q.size() < acc_q.size()) && c < 3000) begin
      bit iv   = (acc_q.size() < 100) && ($urandom_range(0, 1) == 1);
      bit ordy = ($urandom_range(0, 1) == 1);
      drive_cycle(iv, DW'($urandom), ordy, 1'b0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL stall_cycle c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      if (pv === 1'b1 && !pr && obs_valid === 1'b1) begin
        checks++;
        if (obs_data !== pd) begin
          failures++;
          $display("FAIL stall_stable c=%0d got=%h exp=%h", c, obs_data, pd);
        end
      end
      pv = obs_valid; pr = ordy; pd = obs_data;
      c++;
    end
    checks++;
    if (c >= 3000) begin
      failures++;
      $display("FAIL stall_timeout got=%0d delivered exp=%0d", got_q.size(), acc_q.size());
    end
    checks++;
    begin
      bit ok = (got_q.size() == acc_q.size()) && (acc_q.size() >= 100);
      for (int i = 0; i < got_q.size() && ok; i++) ok = (got_q[i] === acc_q[i]);
      if (!ok) begin
        failures++;
        $display("FAIL stall_order got_n=%0d exp_n=%0d", got_q.size(), acc_q.size());
      end
    end
  endtask

  task automatic test_flush();
    clear_boards();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs_ready !== 1'b0 || obs_count !== 3'd3) begin
      failures++;
      $display("FAIL flush_cycle got=rdy%b c%0d exp=rdy0 c3", obs_ready, obs_count);
    end
    drive_cycle(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_valid !== 1'b0 || obs_count !== 3'd0 || obs_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_after got=v%b c%0d rdy%b exp=v0 c0 rdy1", obs_valid, obs_count, obs_ready);
    end
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL flush_drain c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      failures++;
      $display("FAIL flush_output got_n=%0d exp_n=1 exp=5a", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int first_v = -1;
    clear_boards();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, DW'(8'hB0 + i), 1'b0, 1'b0, 1'b1);
    drive_cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_ready got=%b exp=0", obs_ready);
    end
    for (int c = 0; c < 6; c++) begin
      drive_cycle(c == 0, 8'h3C, 1'b1, 1'b0, 1'b1);
      if (c == 0) begin
        checks++;
        if (obs_valid !== 1'b0 || obs_count !== 3'd0 || obs_ready !== 1'b1) begin
          failures++;
          $display("FAIL rstmid_after got=v%b c%0d rdy%b exp=v0 c0 rdy1",
                   obs_valid, obs_count, obs_ready);
        end
      end
      if (obs_valid === 1'b1 && first_v < 0) first_v = c;
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL rstmid_cycle c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
    end
    checks++;
    if (first_v != 2 || got_q.size() != 1 || got_q[0] !== 8'h3C) begin
      failures++;
      $display("FAIL rstmid_output got=first%0d n%0d exp=first2 n1 data3c", first_v, got_q.size());
    end
  endtask

  initial begin
    reset_ni    = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    m_ov        = 1'b0;
    m_od        = '0;
    @(posedge clock_i);
    #1;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
